// File: rtl/debounce3.sv
// debounce3: three-channel synchronizer + debounce filter
// feeding the AND stage, with registered edge pulses.
module debounce3 #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] sw_in,
  output logic [2:0] stable,
  output logic [2:0] rise,
  output logic [2:0] fall
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       s1;
  logic [2:0]       s2;
  logic [CNT_W-1:0] cnt   [3];
  logic [CNT_W-1:0] cnt_n [3];
  logic [2:0]       flip;

  // Two-flop synchronizer; metastability stays in s1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
    end
  end

  // Per-channel count of consecutive cycles s2 disagrees
  // with stable; flip once the disagreement is long enough.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_n[i] = '0;
      flip[i]  = 1'b0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          flip[i] = 1'b1;
        end else begin
          cnt_n[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Counter, level and edge-pulse registers per channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
      stable <= '0;
      rise   <= '0;
      fall   <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= cnt_n[i];
      end
      stable <= stable ^ flip;
      rise   <= flip & s2;
      fall   <= flip & ~s2;
    end
  end

endmodule

// File: tb/tb_debounce3.sv
// tb_debounce3: directed stimulus with a queue scoreboard
// checking a default build and a DEBOUNCE_CYCLES=1 build.
module tb_debounce3;

  logic       clk;
  logic       reset_n;
  logic [2:0] sw_a;
  logic [2:0] sw_b;
  logic [2:0] st_a, ri_a, fa_a;
  logic [2:0] st_b, ri_b, fa_b;

  typedef struct {
    logic [8:0] e0;
    logic [8:0] e1;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 0;
  bit   mon_done = 0;

  debounce3 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sw_in   (sw_a),
    .stable  (st_a),
    .rise    (ri_a),
    .fall    (fa_a)
  );

  debounce3 #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .sw_in   (sw_b),
    .stable  (st_b),
    .rise    (ri_b),
    .fall    (fa_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] E(
    input logic [2:0] s,
    input logic [2:0] r,
    input logic [2:0] f
  );
    return {s, r, f};
  endfunction

  // Each call drives inputs ahead of the next rising edge
  // and queues the outputs expected right after that edge.
  task automatic tick(
    input logic [2:0] a,
    input logic [2:0] b,
    input logic [8:0] e0,
    input logic [8:0] e1,
    input string      tag,
    input int         n = 1
  );
    exp_t x;
    repeat (n) begin
      sw_a = a;
      sw_b = b;
      x.e0 = e0;
      x.e1 = e1;
      x.tag = tag;
      q.push_back(x);
      @(negedge clk);
      #1;
    end
  endtask

  // Monitor: compare sampled outputs on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if ({st_a, ri_a, fa_a} !== x.e0) begin
        failures++;
        $display("FAIL %s dut: got s/r/f=%b/%b/%b want %b/%b/%b",
          x.tag, st_a, ri_a, fa_a,
          x.e0[8:6], x.e0[5:3], x.e0[2:0]);
      end
      checks++;
      if ({st_b, ri_b, fa_b} !== x.e1) begin
        failures++;
        $display("FAIL %s dut1: got s/r/f=%b/%b/%b want %b/%b/%b",
          x.tag, st_b, ri_b, fa_b,
          x.e1[8:6], x.e1[5:3], x.e1[2:0]);
      end
    end else if (done && !mon_done) begin
      checks++;
      if (q.size() != 0) begin
        failures++;
        $display("FAIL drain: got %0d left want 0", q.size());
      end
      mon_done = 1;
    end
  end

  localparam logic [8:0] Z = 9'd0;

  initial begin
    reset_n = 1'b0;
    sw_a = 3'b111;
    sw_b = 3'b111;

    // Held reset with inputs high
    tick(3'b111, 3'b111, Z, Z, "rst_hold", 4);
    reset_n = 1'b1;
    tick(3'b000, 3'b000, Z, Z, "idle", 3);

    // Clean step on channel 0, then release
    tick(3'b001, 3'b000, Z, Z, "step", 5);
    tick(3'b001, 3'b000, E(3'b001, 3'b001, 3'b000), Z, "step");
    tick(3'b001, 3'b000, E(3'b001, 3'b000, 3'b000), Z, "step", 3);
    tick(3'b000, 3'b000, E(3'b001, 3'b000, 3'b000), Z, "step_clr", 5);
    tick(3'b000, 3'b000, E(3'b000, 3'b000, 3'b001), Z, "step_clr");
    tick(3'b000, 3'b000, Z, Z, "step_clr", 2);

    // 3-cycle glitch on channel 1 is rejected
    tick(3'b010, 3'b000, Z, Z, "glitch3", 3);
    tick(3'b000, 3'b000, Z, Z, "glitch3", 8);

    // 4-cycle pulse on channel 1 is accepted
    tick(3'b010, 3'b000, Z, Z, "pulse4", 4);
    tick(3'b000, 3'b000, Z, Z, "pulse4");
    tick(3'b000, 3'b000, E(3'b010, 3'b010, 3'b000), Z, "pulse4");
    tick(3'b000, 3'b000, E(3'b010, 3'b000, 3'b000), Z, "pulse4", 3);
    tick(3'b000, 3'b000, E(3'b000, 3'b000, 3'b010), Z, "pulse4");
    tick(3'b000, 3'b000, Z, Z, "pulse4", 2);

    // Bounce 1,0,1,0,1 then hold on channel 2
    tick(3'b100, 3'b000, Z, Z, "bounce");
    tick(3'b000, 3'b000, Z, Z, "bounce");
    tick(3'b100, 3'b000, Z, Z, "bounce");
    tick(3'b000, 3'b000, Z, Z, "bounce");
    tick(3'b100, 3'b000, Z, Z, "bounce", 5);
    tick(3'b100, 3'b000, E(3'b100, 3'b100, 3'b000), Z, "bounce");
    tick(3'b100, 3'b000, E(3'b100, 3'b000, 3'b000), Z, "bounce", 2);
    tick(3'b000, 3'b000, E(3'b100, 3'b000, 3'b000), Z, "bnc_clr", 5);
    tick(3'b000, 3'b000, E(3'b000, 3'b000, 3'b100), Z, "bnc_clr");
    tick(3'b000, 3'b000, Z, Z, "bnc_clr", 2);

    // All channels together, then drop channel 0 only
    tick(3'b111, 3'b000, Z, Z, "par", 5);
    tick(3'b111, 3'b000, E(3'b111, 3'b111, 3'b000), Z, "par");
    tick(3'b111, 3'b000, E(3'b111, 3'b000, 3'b000), Z, "par", 2);
    tick(3'b110, 3'b000, E(3'b111, 3'b000, 3'b000), Z, "par_c0", 5);
    tick(3'b110, 3'b000, E(3'b110, 3'b000, 3'b001), Z, "par_c0");
    tick(3'b110, 3'b000, E(3'b110, 3'b000, 3'b000), Z, "par_c0", 2);
    tick(3'b111, 3'b000, E(3'b110, 3'b000, 3'b000), Z, "par_s0", 5);
    tick(3'b111, 3'b000, E(3'b111, 3'b001, 3'b000), Z, "par_s0");
    tick(3'b111, 3'b000, E(3'b111, 3'b000, 3'b000), Z, "par_s0");

    // Asynchronous reset right after a rising edge
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    tick(3'b111, 3'b000, Z, Z, "arst");
    tick(3'b111, 3'b000, Z, Z, "arst_hold", 2);
    reset_n = 1'b1;

    // Reset in the middle of a pending count
    tick(3'b111, 3'b000, Z, Z, "midcnt", 3);
    reset_n = 1'b0;
    tick(3'b111, 3'b000, Z, Z, "midcnt_rst", 2);
    reset_n = 1'b1;
    tick(3'b111, 3'b000, Z, Z, "relat", 5);
    tick(3'b111, 3'b000, E(3'b111, 3'b111, 3'b000), Z, "relat");
    tick(3'b111, 3'b000, E(3'b111, 3'b000, 3'b000), Z, "relat");
    tick(3'b000, 3'b000, E(3'b111, 3'b000, 3'b000), Z, "rel_clr", 5);
    tick(3'b000, 3'b000, E(3'b000, 3'b000, 3'b111), Z, "rel_clr");
    tick(3'b000, 3'b000, Z, Z, "rel_clr", 2);

    // DEBOUNCE_CYCLES=1: one-cycle pulse passes through
    tick(3'b000, 3'b001, Z, Z, "dc1");
    tick(3'b000, 3'b000, Z, Z, "dc1");
    tick(3'b000, 3'b000, Z, E(3'b001, 3'b001, 3'b000), "dc1");
    tick(3'b000, 3'b000, Z, E(3'b000, 3'b000, 3'b001), "dc1");
    tick(3'b000, 3'b000, Z, Z, "dc1", 2);

    // DEBOUNCE_CYCLES=1: three-cycle level on two channels
    tick(3'b000, 3'b110, Z, Z, "dc1_multi", 2);
    tick(3'b000, 3'b110, Z, E(3'b110, 3'b110, 3'b000), "dc1_multi");
    tick(3'b000, 3'b000, Z, E(3'b110, 3'b000, 3'b000), "dc1_multi");
    tick(3'b000, 3'b000, Z, E(3'b110, 3'b000, 3'b000), "dc1_multi");
    tick(3'b000, 3'b000, Z, E(3'b000, 3'b000, 3'b110), "dc1_multi");
    tick(3'b000, 3'b000, Z, Z, "dc1_multi", 2);

    done = 1;
    for (int i = 0; i < 4 && !mon_done; i++) begin
      @(negedge clk);
      #1;
    end
    if (!mon_done) begin
      $display("FAIL monitor: got no drain check want drain check");
      $fatal(1, "monitor did not finish");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debounce3.md
# debounce3

Three-channel input conditioner placed directly upstream of the three-input AND stage. Each raw switch/button input passes through a two-flop synchronizer and a per-channel debounce counter. The block then presents clean levels (`stable[2:0]`) that drive the AND inputs a, b and c. It also emits one-cycle rising and falling edge pulses per channel for downstream counters.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized cycles a new level must persist before `stable` adopts it; legal range 1..65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`, minimum 1: width of each channel counter (derived; never overridden).

- `clk`  input  1  single system clock; all state updates on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to `clk` at system level.
- `sw_in`  input  3  raw asynchronous inputs; bit 0 → a, bit 1 → b, bit 2 → c.
- `stable`  output  3  debounced registered levels; feed the AND stage.
- `rise`  output  3  one-cycle pulse per channel when `stable[i]` goes 0→1.
- `fall`  output  3  one-cycle pulse per channel when `stable[i]` goes 1→0.

## Operation
- Channels are fully independent and identical. There is no cross-channel interaction.
- Per channel i, the synchronizer is `s1[i] <= sw_in[i]`, then `s2[i] <= s1[i]`. Only `s2` is used downstream.
- The counter `cnt[i]` (`CNT_W` bits) updates each edge:
  - `s2[i] == stable[i]`: `cnt[i] <= 0`. A mismatch shorter than `DEBOUNCE_CYCLES` is discarded.
  - `s2[i] != stable[i]` and `cnt[i] < DEBOUNCE_CYCLES-1`: `cnt[i] <= cnt[i]+1`.
  - `s2[i] != stable[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: `stable[i] <= s2[i]`, `cnt[i] <= 0`.
- `rise[i]` and `fall[i]` are registered and update on the same edge as `stable[i]`:
  - `rise[i] = 1` for exactly the cycle after `stable[i]` flips 0→1.
  - `fall[i] = 1` for exactly the cycle after `stable[i]` flips 1→0.
  - Both are 0 otherwise. `rise[i]` and `fall[i]` are never both 1.
- The counter never exceeds `DEBOUNCE_CYCLES-1` and never wraps.
- With `DEBOUNCE_CYCLES = 1`, `stable` follows `s2` one edge later with no filtering.
- Simultaneous changes on several channels are processed in parallel. Each channel flips on its own count.
- The implementation has no state machine beyond the per-channel counter/level pair.

## Timing
- Reset (`reset_n` = 0), asynchronous: `s1`, `s2`, `cnt`, `stable`, `rise` and `fall` all clear to 0. Outputs read 0 while reset is held.
- Reset mid-count: the pending change is abandoned. After release, a still-high input requires the full latency again.
- Latency: `sw_in[i]` changes before edge 1 and is held steady.
  - `s2` reflects the change after edge 2.
  - The counter advances on edges 3 .. DEBOUNCE_CYCLES+1.
  - `stable[i]` and the matching pulse change at edge `DEBOUNCE_CYCLES+2`. For the default, that is edge 6.
- Minimum accepted pulse width: a level must be held at `s2` for `DEBOUNCE_CYCLES` consecutive cycles. Any reversal resets the count to 0.
- `sw_in` may change at any time relative to `clk`. Metastability is confined to `s1`.
- The first edge after reset release, with `sw_in` = 0, produces no activity on any output.

## Test plan
- Reset check: hold `reset_n` = 0 with `sw_in` = 3'b111 and toggle `clk` → `stable`, `rise` and `fall` all stay 3'b000. Assert `reset_n` = 0 asynchronously mid-cycle after `stable` = 3'b111 → all outputs read 0 before the next edge.
- Clean step, default parameter: `sw_in` 3'b000→3'b001 before edge 1 and held → `stable` = 3'b001 and `rise` = 3'b001 after edge 6. `rise` = 3'b000 after edge 7. `fall` stays 0 throughout.
- Glitch rejection: pulse `sw_in[1]` high for 3 cycles, then low → `stable[1]`, `rise[1]` and `fall[1]` remain 0. Repeat with a 4-cycle pulse → `rise[1]` pulses once and `fall[1]` pulses once, 4 cycles later.
- Bounce then settle: `sw_in[2]` toggles 1,0,1,0,1 on successive cycles, then holds 1 → exactly one `rise[2]` pulse, occurring 6 edges after the final 0→1 transition.
- Parallel channels: `sw_in` 3'b000→3'b111 together → `stable` = 3'b111 and `rise` = 3'b111 on the same edge. Then clear only `sw_in[0]` → `stable` = 3'b110 and `fall` = 3'b001; channels 1 and 2 are unaffected.
- `DEBOUNCE_CYCLES` = 1 build: a single-cycle high on `sw_in[0]` at `s2` → `stable[0]` high for one cycle, with `rise[0]` then `fall[0]` on consecutive edges.
